// File: rtl/du_inst_loader_pkg.sv
// Shared definitions for the debug-unit program loader: FSM encoding,
// end-of-program marker and byte-lane geometry.
package du_inst_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned NB_REG_C   = 32;
  localparam int unsigned NB_BYTE_C  = 8;
  localparam int unsigned NB_LANES_C = NB_REG_C / NB_BYTE_C;

  localparam logic [NB_REG_C-1:0] HALT_WORD_C = 32'hFFFF_FFFF;

endpackage

// File: rtl/du_inst_loader_packer.sv
// Little-endian byte packer: drops each shifted-in byte into the lane selected
// by a wrapping lane counter and exposes the word including the current byte.
module du_inst_loader_packer
  import du_inst_loader_pkg::*;
#(
  parameter int unsigned NB_BYTE  = NB_BYTE_C,
  parameter int unsigned NB_LANES = NB_LANES_C
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear,
  input  logic                        i_shift,
  input  logic [NB_BYTE-1:0]          i_byte,
  output logic                        o_last,
  output logic [NB_BYTE*NB_LANES-1:0] o_word_next
);

  localparam int unsigned CW = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;

  logic [CW-1:0]                cnt_q, cnt_d;
  logic [NB_BYTE*NB_LANES-1:0]  word_q, word_d;

  assign o_last      = (cnt_q == CW'(NB_LANES - 1));
  assign o_word_next = word_d;

  // NOTE: every variable gets a default before the branches, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (i_clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (i_shift) begin
      word_d[cnt_q*NB_BYTE +: NB_BYTE] = i_byte;
      cnt_d = o_last ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/du_inst_loader.sv
// Program loader: pops UART RX bytes, packs them into instructions and writes
// them to consecutive instruction-memory words until HALT_WORD or memory full.
module du_inst_loader
  import du_inst_loader_pkg::*;
#(
  parameter int unsigned       NB_REG    = NB_REG_C,
  parameter int unsigned       NB_BYTE   = NB_BYTE_C,
  parameter int unsigned       NB_WIDHT  = 9,
  parameter logic [NB_REG-1:0] HALT_WORD = HALT_WORD_C
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_rx_empty,
  input  logic [NB_BYTE-1:0] i_rx_data,
  output logic               o_rx_rd,
  output logic               o_w_mem,
  output logic [NB_REG-1:0]  o_inst,
  output logic [NB_REG-1:0]  o_addr_inst,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow
);

  localparam int unsigned LANES = NB_REG / NB_BYTE;

  state_e                state_q, state_d;
  logic [NB_WIDHT-1:0]   word_idx_q, word_idx_d;
  logic [NB_REG-1:0]     inst_q, inst_d;
  logic [NB_REG-1:0]     addr_q, addr_d;
  logic                  overflow_q, overflow_d;

  logic                  pk_clear, pk_shift, pk_last;
  logic [NB_REG-1:0]     pk_word_next;

  du_inst_loader_packer #(
    .NB_BYTE  (NB_BYTE),
    .NB_LANES (LANES)
  ) u_packer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (pk_clear),
    .i_shift     (pk_shift),
    .i_byte      (i_rx_data),
    .o_last      (pk_last),
    .o_word_next (pk_word_next)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    inst_d     = inst_q;
    addr_d     = addr_q;
    overflow_d = overflow_q;
    pk_clear   = 1'b0;
    pk_shift   = 1'b0;
    o_rx_rd    = 1'b0;
    o_done     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          word_idx_d = '0;
          overflow_d = 1'b0;
          pk_clear   = 1'b1;
          state_d    = ST_RECV;
        end
      end

      ST_RECV: begin
        if (i_abort) begin
          pk_clear = 1'b1;
          state_d  = ST_IDLE;
        end else if (!i_rx_empty) begin
          o_rx_rd  = 1'b1;
          pk_shift = 1'b1;
          if (pk_last) begin
            // Latch word and address together so both are stable in WRITE.
            inst_d = pk_word_next;
            addr_d = '0;
            addr_d[NB_WIDHT+1:0] = {word_idx_q, 2'b00};
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (inst_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (word_idx_q == '1) begin
          overflow_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = ST_RECV;
        end
      end

      ST_DONE: begin
        o_done  = !i_abort;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      inst_q     <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      inst_q     <= inst_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_w_mem     = (state_q == ST_WRITE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_inst      = inst_q;
  assign o_addr_inst = addr_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_du_inst_loader.sv
// Scoreboard bench for du_inst_loader: a full-depth instance for normal loads
// and a 4-word instance for the overflow case share one modelled RX FIFO.
module tb_du_inst_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, abort;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        sel;

  logic        rd_a, wm_a, busy_a, done_a, ovf_a;
  logic [31:0] inst_a, addr_a;
  logic        rd_b, wm_b, busy_b, done_b, ovf_b;
  logic [31:0] inst_b, addr_b;

  int   n_checks = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  du_inst_loader #(.NB_WIDHT(9)) u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_start(start_a), .i_abort(abort),
    .i_rx_empty(rx_empty), .i_rx_data(rx_data), .o_rx_rd(rd_a),
    .o_w_mem(wm_a), .o_inst(inst_a), .o_addr_inst(addr_a),
    .o_busy(busy_a), .o_done(done_a), .o_overflow(ovf_a)
  );

  du_inst_loader #(.NB_WIDHT(2)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_start(start_b), .i_abort(abort),
    .i_rx_empty(rx_empty), .i_rx_data(rx_data), .o_rx_rd(rd_b),
    .o_w_mem(wm_b), .o_inst(inst_b), .o_addr_inst(addr_b),
    .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b)
  );

  wire        rd_s   = sel ? rd_b   : rd_a;
  wire        wm_s   = sel ? wm_b   : wm_a;
  wire        busy_s = sel ? busy_b : busy_a;
  wire        done_s = sel ? done_b : done_a;
  wire        ovf_s  = sel ? ovf_b  : ovf_a;
  wire [31:0] inst_s = sel ? inst_b : inst_a;
  wire [31:0] addr_s = sel ? addr_b : addr_a;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_s) check("rd_while_empty", {31'd0, rx_empty}, 32'd0);
      if (wm_s) begin
        check("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("addr", addr_s, e.addr);
          check("inst", inst_s, e.inst);
        end
      end
      if (done_s) done_cnt++;
    end
  end

  task automatic pulse_start();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Offer one byte (after an optional stall) and wait for the DUT to pop it.
  task automatic push_byte(input logic [7:0] b, input int stall);
    rx_empty = 1'b1;
    repeat (stall) @(negedge clk);
    rx_data  = b;
    rx_empty = 1'b0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (rd_s) break;
      if (n == 59) begin
        check("pop_timeout", {31'd0, rd_s}, 32'd1);
        rx_empty = 1'b1;
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rx_empty = 1'b1;
  endtask

  task automatic wait_done(input logic exp_ovf);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_s) break;
    end
    check("done_seen", {31'd0, done_s}, 32'd1);
    check("overflow", {31'd0, ovf_s}, {31'd0, exp_ovf});
    check("sb_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done_s}, 32'd0);
    check("busy_after_done", {31'd0, busy_s}, 32'd0);
  endtask

  task automatic load(input logic [31:0] words[$], input int max_stall,
                      input bit poke_start, input logic exp_ovf);
    logic [31:0] a;
    logic [31:0] w;
    a = 32'd0;
    pulse_start();
    foreach (words[i]) begin
      w = words[i];
      exp_q.push_back('{addr: a, inst: w});
      a += 32'd4;
      for (int b = 0; b < 4; b++) begin
        push_byte(w[8*b +: 8], (max_stall > 0) ? int'($urandom_range(1, max_stall)) : 0);
        if (poke_start && i == 1 && b == 0) pulse_start();
      end
    end
    wait_done(exp_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] basic[$];
    logic [31:0] reload[$];
    logic [31:0] four[$];
    int          d0;

    basic  = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    reload = '{32'h1122_3344, 32'hFFFF_FFFF};
    four   = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};

    sel = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    rx_empty = 1'b1; rx_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_inst", inst_a, 32'd0);
    check("rst_addr", addr_a, 32'd0);
    check("rst_ovf",  {31'd0, ovf_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load, then the same bytes with FIFO stalls.
    load(basic, 0, 1'b0, 1'b0);
    load(basic, 3, 1'b0, 1'b0);

    // Abort together with start in IDLE: abort wins.
    start_a = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort = 1'b0;
    #1 check("abort_start_idle", {31'd0, busy_a}, 32'd0);

    // Abort after two bytes of the first word, then a clean reload.
    d0 = done_cnt;
    pulse_start();
    push_byte(8'hAA, 0);
    push_byte(8'hBB, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_idle", {31'd0, busy_a}, 32'd0);
    check("abort_no_done", done_cnt, d0);
    load(reload, 0, 1'b0, 1'b0);

    // Second start while receiving must not restart the address sequence.
    load(basic, 1, 1'b1, 1'b0);

    // Asynchronous reset during RECV with a byte pending.
    pulse_start();
    push_byte(8'h01, 0);
    push_byte(8'h02, 0);
    rx_data = 8'h5A; rx_empty = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd",   {31'd0, rd_a},   32'd0);
    check("arst_wmem", {31'd0, wm_a},   32'd0);
    check("arst_busy", {31'd0, busy_a}, 32'd0);
    check("arst_done", {31'd0, done_a}, 32'd0);
    check("arst_ovf",  {31'd0, ovf_a},  32'd0);
    check("arst_inst", inst_a, 32'd0);
    check("arst_addr", addr_a, 32'd0);
    @(posedge clk);
    #1 check("arst_rd_held", {31'd0, rd_a}, 32'd0);
    @(negedge clk);
    rx_empty = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Overflow on the 4-word instance: no halt word, no fifth pop.
    sel = 1'b1;
    load(four, 0, 1'b0, 1'b1);
    rx_data = 8'h99; rx_empty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("no_pop_after_ovf", {31'd0, rd_b}, 32'd0);
      @(negedge clk);
    end
    rx_empty = 1'b1;
    check("ovf_sticky", {31'd0, ovf_b}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
